rotate_seg_anim: RTL and testbench
==================================

# rotate_seg_anim

Parametrised rotating-square animation driver for an N-digit 7-segment display. A small square is stepped around a loop of 2·N_DIGITS positions: along the top half of the digits, then back along the bottom half. Step rate is programmable at run time, direction is selectable, and single-stepping is supported while paused. The block sits between the board clock and the display pins, and replaces the fixed 4-digit, fixed-rate animation.

## Interface
- N_DIGITS, 4: number of digits; must be ≥ 2; positions = 2·N_DIGITS.
- RATE_W, 24: width of the step-rate divider.
- POS_W, $clog2(2·N_DIGITS): position width (derived, not overridden).

- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- en  in  1  run enable; 1 = auto-advance at programmed rate.
- cw  in  1  direction; 1 = clockwise (position increments), 0 = counter-clockwise (decrements).
- rate  in  RATE_W  divider terminal count; one step every rate+1 cycles.
- step  in  1  single-step request, sampled per cycle; honoured only while en=0.
- seg  out  7  segment drive, abcdefg order (bit 6 = a), active-high.
- an  out  N_DIGITS  digit enable, one-hot, active-high; bit N_DIGITS-1 = leftmost digit.
- pos  out  POS_W  current position, 0..2·N_DIGITS-1.
- wrap  out  1  one-cycle pulse when pos crosses the loop boundary.

## Operation
- Pattern is decoded from pos only:
  - p < N: seg = SEG_TOP (1100011, segments a,b,f,g), an = one-hot bit N-1-p.
  - p ≥ N: seg = SEG_BOT (0011101, segments c,d,e,g), an = one-hot bit p-N.
  - Bit numbering places pos N on the rightmost digit and pos 2N-1 on the leftmost.
- Advance event (adv) is asserted when either condition holds:
  - en=1 and the divider tick fires;
  - en=0 and step=1.
- On adv:
  - cw=1: pos ← pos+1, wrapping 2N-1 → 0.
  - cw=0: pos ← pos-1, wrapping 0 → 2N-1.
  - Non-power-of-two loop lengths must wrap explicitly. The bare counter must never overflow into an unused code.
- Divider (count, RATE_W bits):
  - While en=1: if count ≥ rate, then tick=1 and count ← 0; otherwise count ← count+1.
  - While en=0: count ← 0.
- Direction changes take effect at the next adv. pos is never modified by a change of cw alone.
- Raising en restarts the divider from 0.
- wrap is registered. It is 1 in the cycle where pos first shows the post-wrap value (0 for cw, 2N-1 for ccw). Otherwise it is 0.

## Timing
- Reset values (cycle after reset sampled low):
  - pos = 0, count = 0, wrap = 0;
  - seg = 1100011;
  - an = one-hot bit N-1.
- pos and wrap are registered. seg and an are combinational from pos, so they share pos's timing.
- en=1: the first step occurs rate+1 cycles after en rises. Steps then repeat every rate+1 cycles. rate=0 → one step every cycle.
- step while en=0: pos updates on the next rising edge. A step held high for k cycles yields k steps.
- step while en=1 is ignored.
- A rate change mid-count applies immediately through the ≥ compare. If the new rate is ≤ count, tick fires on the next cycle.
- en falling on a tick cycle: that tick is still taken. No further auto steps follow.
- reset asserted mid-animation: all state returns to reset values at the next edge, overriding adv.

## Structure
- Package rotate_seg_pkg holds:
  - SEG_TOP, SEG_BOT, SEG_OFF (0000000) localparams;
  - a function returning the one-hot anode for a given (pos, N_DIGITS).
- Sub-module rate_tick (clk, reset, en, rate → tick) holds the divider. The top level holds the position counter, wrap register and decode.

## Test plan
- N=4, rate=3, en=1, cw=1 after reset → steps every 4 cycles; pos 0,1,…,7,0. an goes 1000,0100,0010,0001 with seg=1100011, then 0001,0010,0100,1000 with seg=0011101. wrap is 1 for exactly one cycle at the 7→0 transition.
- N=4, cw=0 from reset → pos 0,7,6,5…; wrap pulses at 0→7. Toggling cw at pos=5 → next step goes to pos 6 with no skip.
- en=0, step pulsed 3 single cycles then held 2 cycles → pos advances 0→3→5. Step with en=1 produces no extra advance beyond the rate ticks.
- rate=0 → pos changes every cycle. rate reduced from 100 to 2 when count=50 → tick on the next cycle, then every 3 cycles.
- N=5 (non-power-of-two, 10 positions), cw=1 → pos 9→0 with wrap. For pos 5, an=00001 and seg=0011101.
- reset pulled low for 1 cycle at pos=6 mid-count → next cycle pos=0, wrap=0, an=1000, seg=1100011. The first auto step comes rate+1 cycles after reset releases.

Source files
------------

// File: rtl/rotate_seg_pkg.sv
// Shared constants and helpers for the rotating-square display animation.
// Holds the segment patterns for the upper and lower square and a function
// that turns a loop position into the one-hot digit enable.
package rotate_seg_pkg;

    // Segment order is abcdefg, so bit 6 is segment a. All patterns are active-high.
    localparam logic [6:0] SEG_TOP = 7'b1100011;  // a, b, f, g: square in the upper half
    localparam logic [6:0] SEG_BOT = 7'b0011101;  // c, d, e, g: square in the lower half
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Largest digit count the anode helper can describe.
    localparam int MAX_DIGITS = 32;

    // One-hot anode for loop position p on an n-digit display.
    // The upper pass runs from the leftmost digit (bit n-1) to the right.
    // The lower pass runs back from the rightmost digit (bit 0) to the left.
    // Callers truncate the result to their own digit count.
    function automatic logic [MAX_DIGITS-1:0] anode_onehot(input int p, input int n);
        logic [MAX_DIGITS-1:0] one;
        one = {{(MAX_DIGITS-1){1'b0}}, 1'b1};
        if (p < n) begin
            return one << (n - 1 - p);
        end
        return one << (p - n);
    endfunction

endpackage

// File: rtl/rotate_seg_anim_rate_tick.sv
// rate_tick: programmable step-rate divider for the animation.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-low reset
//   en    - run enable. While low, the counter is held at 0, so raising en
//           always starts a full period.
//   rate  - terminal count. One tick is produced every rate+1 enabled cycles.
//   tick  - combinational; high in the cycle whose rising edge takes the step.
module rate_tick #(
    parameter int RATE_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [RATE_W-1:0] rate,
    output logic              tick
);

    logic [RATE_W-1:0] count;

    // The compare is ">=" rather than "==". Lowering rate below the current
    // count then fires on the next cycle instead of running the counter
    // all the way round.
    assign tick = en && (count >= rate);

    // NOTE: state registers use non-blocking (<=) assignments so every flop
    // samples its inputs at the same edge, independent of statement order.
    // NOTE: reset is synchronous and sampled here. It is checked before
    // anything else, so it overrides any pending tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (!en || tick) begin
            count <= '0;
        end else begin
            count <= count + RATE_W'(1);
        end
    end

endmodule

// File: rtl/rotate_seg_anim.sv
// rotate_seg_anim: rotating-square animation for an N-digit 7-segment display.
// A square steps around 2*N_DIGITS positions: first left to right across the
// top halves of the digits, then right to left across the bottom halves.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-low reset
//   en    - 1: advance automatically at the programmed rate
//   cw    - 1: position increments, 0: position decrements
//   rate  - divider terminal count; one step every rate+1 cycles
//   step  - single-step request, used only while en=0
//   seg   - segments abcdefg (bit 6 = a), active-high, decoded from pos
//   an    - one-hot digit enable, bit N_DIGITS-1 = leftmost digit
//   pos   - current loop position, 0 .. 2*N_DIGITS-1
//   wrap  - high for the one cycle in which pos first shows the post-wrap value
module rotate_seg_anim
    import rotate_seg_pkg::*;
#(
    parameter  int N_DIGITS = 4,
    parameter  int RATE_W   = 24,
    localparam int POS_W    = $clog2(2 * N_DIGITS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                cw,
    input  logic [RATE_W-1:0]   rate,
    input  logic                step,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] an,
    output logic [POS_W-1:0]    pos,
    output logic                wrap
);

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(2 * N_DIGITS - 1);
    localparam logic [POS_W-1:0] HALF_POS = POS_W'(N_DIGITS);

    logic             tick;
    logic             adv;
    logic [POS_W-1:0] pos_next;
    logic             wrap_next;

    rate_tick #(
        .RATE_W(RATE_W)
    ) u_rate_tick (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .rate (rate),
        .tick (tick)
    );

    // Steps come from the divider while running and from step while paused,
    // never from both.
    assign adv = en ? tick : step;

    // The loop length need not be a power of two, so both ends wrap
    // explicitly. pos can never reach an unused code.
    // NOTE: every output of this block gets a default at the top. Paths that
    // do not assign it then hold the default instead of inferring a latch.
    always_comb begin
        pos_next  = pos;
        wrap_next = 1'b0;
        if (adv) begin
            if (cw) begin
                if (pos == LAST_POS) begin
                    pos_next  = '0;
                    wrap_next = 1'b1;
                end else begin
                    pos_next = pos + POS_W'(1);
                end
            end else begin
                if (pos == '0) begin
                    pos_next  = LAST_POS;
                    wrap_next = 1'b1;
                end else begin
                    pos_next = pos - POS_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pos  <= '0;
            wrap <= 1'b0;
        end else begin
            pos  <= pos_next;
            wrap <= wrap_next;
        end
    end

    // seg and an are decoded from the registered pos, so they change in the
    // same cycle as pos.
    always_comb begin
        seg = SEG_OFF;
        if (pos < HALF_POS) begin
            seg = SEG_TOP;
        end else begin
            seg = SEG_BOT;
        end
        an = N_DIGITS'(anode_onehot(int'(pos), N_DIGITS));
    end

endmodule

// File: tb/tb_rotate_seg_anim.sv
// Directed testbench for rotate_seg_anim.
// Two instances (N=4 and N=5) are driven by the same inputs.
// Inputs change 1 time unit after a rising edge, and outputs are sampled at
// that same point, well away from the next edge.
module tb_rotate_seg_anim;

    localparam logic [6:0] TOP = 7'b1100011;
    localparam logic [6:0] BOT = 7'b0011101;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        cw = 1'b1;
    logic        step = 1'b0;
    logic [23:0] rate = '0;

    logic [6:0]  seg4, seg5;
    logic [3:0]  an4;
    logic [4:0]  an5;
    logic [2:0]  pos4;
    logic [3:0]  pos5;
    logic        wrap4, wrap5;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rotate_seg_anim #(.N_DIGITS(4), .RATE_W(24)) dut4 (
        .clk(clk), .reset(reset), .en(en), .cw(cw), .rate(rate), .step(step),
        .seg(seg4), .an(an4), .pos(pos4), .wrap(wrap4)
    );

    rotate_seg_anim #(.N_DIGITS(5), .RATE_W(24)) dut5 (
        .clk(clk), .reset(reset), .en(en), .cw(cw), .rate(rate), .step(step),
        .seg(seg5), .an(an5), .pos(pos5), .wrap(wrap5)
    );

    typedef struct {
        bit         rst;     // pulse reset for one cycle before applying inputs
        bit         en;
        bit         cw;
        bit         step;
        int         rate;
        int         wait_n;  // rising edges to wait before sampling
        int         pos;
        logic [6:0] seg;
        logic [3:0] an;
        bit         wrap;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(bit rst, bit en_i, bit cw_i, bit step_i, int rate_i,
                               int wait_i, int pos_i, logic [6:0] seg_i,
                               logic [3:0] an_i, bit wrap_i);
        vec_t r;
        r.rst = rst; r.en = en_i; r.cw = cw_i; r.step = step_i; r.rate = rate_i;
        r.wait_n = wait_i; r.pos = pos_i; r.seg = seg_i; r.an = an_i; r.wrap = wrap_i;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds reset low across one edge, then releases it.
    task automatic do_reset();
        reset = 1'b0;
        en    = 1'b0;
        step  = 1'b0;
        wait_edges(1);
        reset = 1'b1;
    endtask

    task automatic check4(input string tag, input int p, input logic [6:0] s,
                          input logic [3:0] a, input bit w);
        check({tag, ".pos"},  32'(pos4),  32'(p));
        check({tag, ".seg"},  32'(seg4),  32'(s));
        check({tag, ".an"},   32'(an4),   32'(a));
        check({tag, ".wrap"}, 32'(wrap4), 32'(w));
    endtask

    // Watchdog: every wait is a fixed cycle count, so this only trips if
    // simulation stalls.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //         rst en cw st rate wait pos seg  an       wrap
        // N=4, cw, rate=3: one step every 4 cycles, full loop with wrap at 7->0.
        vecs.push_back(v(1, 1, 1, 0, 3, 4, 1, TOP, 4'b0100, 0));
        vecs.push_back(v(0, 1, 1, 0, 3, 4, 2, TOP, 4'b0010, 0));
        vecs.push_back(v(0, 1, 1, 0, 3, 4, 3, TOP, 4'b0001, 0));
        vecs.push_back(v(0, 1, 1, 0, 3, 4, 4, BOT, 4'b0001, 0));
        vecs.push_back(v(0, 1, 1, 0, 3, 4, 5, BOT, 4'b0010, 0));
        vecs.push_back(v(0, 1, 1, 0, 3, 4, 6, BOT, 4'b0100, 0));
        vecs.push_back(v(0, 1, 1, 0, 3, 4, 7, BOT, 4'b1000, 0));
        vecs.push_back(v(0, 1, 1, 0, 3, 4, 0, TOP, 4'b1000, 1));
        vecs.push_back(v(0, 1, 1, 0, 3, 1, 0, TOP, 4'b1000, 0));
        // ccw from reset: 0 -> 7 wraps; switching to cw at pos 5 goes to 6.
        vecs.push_back(v(1, 1, 0, 0, 3, 4, 7, BOT, 4'b1000, 1));
        vecs.push_back(v(0, 1, 0, 0, 3, 1, 7, BOT, 4'b1000, 0));
        vecs.push_back(v(0, 1, 0, 0, 3, 3, 6, BOT, 4'b0100, 0));
        vecs.push_back(v(0, 1, 0, 0, 3, 4, 5, BOT, 4'b0010, 0));
        vecs.push_back(v(0, 1, 1, 0, 3, 4, 6, BOT, 4'b0100, 0));
        // Paused: three single-cycle steps, then step held for two cycles.
        vecs.push_back(v(1, 0, 1, 1, 3, 1, 1, TOP, 4'b0100, 0));
        vecs.push_back(v(0, 0, 1, 0, 3, 1, 1, TOP, 4'b0100, 0));
        vecs.push_back(v(0, 0, 1, 1, 3, 1, 2, TOP, 4'b0010, 0));
        vecs.push_back(v(0, 0, 1, 0, 3, 1, 2, TOP, 4'b0010, 0));
        vecs.push_back(v(0, 0, 1, 1, 3, 1, 3, TOP, 4'b0001, 0));
        vecs.push_back(v(0, 0, 1, 0, 3, 1, 3, TOP, 4'b0001, 0));
        vecs.push_back(v(0, 0, 1, 1, 3, 2, 5, BOT, 4'b0010, 0));
        vecs.push_back(v(0, 0, 1, 0, 3, 1, 5, BOT, 4'b0010, 0));
        // step held while running is ignored; only the rate tick moves pos.
        vecs.push_back(v(1, 1, 1, 1, 3, 3, 0, TOP, 4'b1000, 0));
        vecs.push_back(v(0, 1, 1, 1, 3, 1, 1, TOP, 4'b0100, 0));
        // rate=0: a step every cycle.
        vecs.push_back(v(1, 1, 1, 0, 0, 1, 1, TOP, 4'b0100, 0));
        vecs.push_back(v(0, 1, 1, 0, 0, 1, 2, TOP, 4'b0010, 0));
        vecs.push_back(v(0, 1, 1, 0, 0, 1, 3, TOP, 4'b0001, 0));
        // rate 100 -> 2 at count 50: tick next cycle, then every 3 cycles.
        vecs.push_back(v(1, 1, 1, 0, 100, 50, 0, TOP, 4'b1000, 0));
        vecs.push_back(v(0, 1, 1, 0, 2,   1,  1, TOP, 4'b0100, 0));
        vecs.push_back(v(0, 1, 1, 0, 2,   2,  1, TOP, 4'b0100, 0));
        vecs.push_back(v(0, 1, 1, 0, 2,   1,  2, TOP, 4'b0010, 0));

        // Reset values.
        wait_edges(2);
        check4("reset", 0, TOP, 4'b1000, 0);
        check("reset.an5", 32'(an5), 32'(5'b10000));
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            en   = vecs[i].en;
            cw   = vecs[i].cw;
            step = vecs[i].step;
            rate = 24'(vecs[i].rate);
            wait_edges(vecs[i].wait_n);
            check4($sformatf("vec%0d", i), vecs[i].pos, vecs[i].seg, vecs[i].an, vecs[i].wrap);
        end

        // Reset for one cycle at pos 6, mid-count.
        do_reset();
        en = 1'b1; cw = 1'b1; step = 1'b0; rate = 24'd3;
        wait_edges(26);
        check("midrst.pre_pos", 32'(pos4), 32'd6);
        reset = 1'b0;
        wait_edges(1);
        check4("midrst", 0, TOP, 4'b1000, 0);
        reset = 1'b1;
        wait_edges(3);
        check("midrst.hold_pos", 32'(pos4), 32'd0);
        wait_edges(1);
        check("midrst.first_pos", 32'(pos4), 32'd1);

        // N=5: ten positions, stepping every cycle.
        do_reset();
        en = 1'b1; cw = 1'b1; rate = 24'd0;
        wait_edges(5);
        check("n5.pos5",  32'(pos5), 32'd5);
        check("n5.an5",   32'(an5),  32'(5'b00001));
        check("n5.seg5",  32'(seg5), 32'(BOT));
        wait_edges(4);
        check("n5.pos9",  32'(pos5),  32'd9);
        check("n5.an9",   32'(an5),   32'(5'b10000));
        check("n5.wrap9", 32'(wrap5), 32'd0);
        wait_edges(1);
        check("n5.pos0",  32'(pos5),  32'd0);
        check("n5.wrap0", 32'(wrap5), 32'd1);
        check("n5.seg0",  32'(seg5),  32'(TOP));
        wait_edges(1);
        check("n5.pos1",  32'(pos5),  32'd1);
        check("n5.wrap1", 32'(wrap5), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
